// File: rtl/coffee_pkg.sv
// rtl/coffee_pkg.sv - shared defaults, FSM encodings and width helpers for the button arbiter
package coffee_pkg;

    localparam int N_BTN_DEF       = 4;
    localparam int LONG_CYCLES_DEF = 50000;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OFFER = 1'b1;

    // Index width for n buttons, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Hold counter width that can hold long_cycles-1.
    function automatic int cnt_w(input int long_cycles);
        return (long_cycles > 2) ? $clog2(long_cycles) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, lowest request at or after ptr
module rr_pick
    import coffee_pkg::*;
#(
    parameter  int N_BTN = N_BTN_DEF,
    localparam int IDX_W = idx_w(N_BTN)
) (
    input  logic [N_BTN-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    // Scan from the farthest offset back to ptr so the nearest request wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = N_BTN - 1; k >= 0; k--) begin
            int j;
            j = (int'(ptr) + k) % N_BTN;
            if (req[j]) begin
                any = 1'b1;
                idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/button_arbiter.sv
// rtl/button_arbiter.sv - round-robin button command arbiter; long press built only with BUTTON_LONG_PRESS_EN
module button_arbiter
    import coffee_pkg::*;
#(
    parameter  int N_BTN       = N_BTN_DEF,
    parameter  int LONG_CYCLES = LONG_CYCLES_DEF,
    localparam int IDX_W       = idx_w(N_BTN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_down,
    input  logic [N_BTN-1:0] btn_state,
    input  logic             cmd_ready,
    output logic             cmd_valid,
    output logic [IDX_W-1:0] cmd_idx,
    output logic             cmd_long,
    output logic [7:0]       drop_cnt
);

    logic [0:0]       state;
    logic [N_BTN-1:0] pending;
    logic [N_BTN-1:0] req;
    logic [N_BTN-1:0] grant_hot;
    logic [N_BTN-1:0] pend_clr;
    logic [N_BTN-1:0] overrun;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             load;

    rr_pick #(
        .N_BTN (N_BTN)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // A new command is loaded from idle, or back-to-back when the current one is taken.
    assign load      = pick_any && ((state == IDLE) || cmd_ready);
    assign grant_hot = load ? (N_BTN'(1) << pick_idx) : '0;
    assign cmd_valid = (state == OFFER);

    // A press on a still-queued, ungranted button is lost; a press on the granted one re-queues.
    assign overrun   = btn_down & pending & ~pend_clr;

`ifdef BUTTON_LONG_PRESS_EN
    localparam int CW = cnt_w(LONG_CYCLES);

    logic [N_BTN-1:0] long_pending;
    logic [N_BTN-1:0] long_set;
    logic [N_BTN-1:0] long_clr;
    logic [CW-1:0]    hold_cnt [N_BTN];
    logic             grant_long;

    assign req        = pending | long_pending;
    assign grant_long = long_pending[pick_idx];
    assign pend_clr   = grant_long ? '0 : grant_hot;
    assign long_clr   = grant_long ? grant_hot : '0;

    // The long flag fires only on the edge the counter arrives at its saturation value.
    always_comb begin
        long_set = '0;
        for (int i = 0; i < N_BTN; i++) begin
            long_set[i] = btn_state[i] && (hold_cnt[i] == CW'(LONG_CYCLES - 2));
        end
    end

    // Per-button hold counters, saturating at LONG_CYCLES-1 and cleared on release.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_BTN; i++) begin
            if (rst || !btn_state[i]) begin
                hold_cnt[i] <= '0;
            end else if (hold_cnt[i] != CW'(LONG_CYCLES - 1)) begin
                hold_cnt[i] <= hold_cnt[i] + 1'b1;
            end
        end
    end

    // Long-press requests; a fresh long press wins over a same-edge grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            long_pending <= '0;
        end else begin
            long_pending <= (long_pending & ~long_clr) | long_set;
        end
    end

    // Command kind captured together with the index.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_long <= 1'b0;
        end else if (load) begin
            cmd_long <= grant_long;
        end
    end
`else
    logic unused_cfg;

    assign req        = pending;
    assign pend_clr   = grant_hot;
    assign cmd_long   = 1'b0;
    assign unused_cfg = (LONG_CYCLES > 0) ^ (^btn_state);
`endif

    // Short-press requests and the saturating, once-per-edge loss counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            drop_cnt <= '0;
        end else begin
            pending <= (pending & ~pend_clr) | btn_down;
            if ((|overrun) && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Offer FSM, held output while stalled, and round-robin pointer advance on each load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            cmd_idx <= '0;
        end else if (load) begin
            state   <= OFFER;
            cmd_idx <= pick_idx;
            ptr     <= (pick_idx == IDX_W'(N_BTN - 1)) ? '0 : pick_idx + 1'b1;
        end else if ((state == OFFER) && cmd_ready) begin
            state   <= IDLE;
        end
    end

endmodule

// File: tb/tb_button_arbiter.sv
// tb/tb_button_arbiter.sv - directed bench with a per-cycle reference model for button_arbiter
module tb_button_arbiter;

    localparam int N  = 4;
    localparam int LC = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_down = '0;
    logic [N-1:0] btn_state = '0;
    logic         cmd_ready = 1'b0;
    logic         cmd_valid;
    logic [1:0]   cmd_idx;
    logic         cmd_long;
    logic [7:0]   drop_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [2:0] hs_q [$];

    bit m_pend [N];
    bit m_long [N];
`ifdef BUTTON_LONG_PRESS_EN
    int m_hold [N];
`endif
    int m_ptr = 0;
    bit m_valid = 1'b0;
    int m_idx = 0;
    bit m_cmdlong = 1'b0;
    int m_drops = 0;

    button_arbiter #(
        .N_BTN       (N),
        .LONG_CYCLES (LC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_down  (btn_down),
        .btn_state (btn_state),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd_idx   (cmd_idx),
        .cmd_long  (cmd_long),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: queue of per-button requests served round-robin, one command per edge.
    always @(posedge clk) begin : model
        int  g;
        bit  drop;
        cyc++;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 1'b0;
                m_long[i] = 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
                m_hold[i] = 0;
`endif
            end
            m_ptr = 0; m_valid = 1'b0; m_idx = 0; m_cmdlong = 1'b0; m_drops = 0;
        end else begin
            if (!m_valid || cmd_ready) begin
                g = -1;
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (g < 0 && (m_pend[j] || m_long[j])) g = j;
                end
                if (g >= 0) begin
                    m_valid = 1'b1;
                    m_idx   = g;
                    if (m_long[g]) begin
                        m_cmdlong = 1'b1;
                        m_long[g] = 1'b0;
                    end else begin
                        m_cmdlong = 1'b0;
                        m_pend[g] = 1'b0;
                    end
                    m_ptr = (g + 1) % N;
                end else begin
                    m_valid = 1'b0;
                end
            end
            drop = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (btn_down[i]) begin
                    if (m_pend[i]) drop = 1'b1;
                    m_pend[i] = 1'b1;
                end
            end
            if (drop && m_drops < 255) m_drops++;
`ifdef BUTTON_LONG_PRESS_EN
            for (int i = 0; i < N; i++) begin
                if (btn_state[i]) begin
                    if (m_hold[i] < LC - 1) begin
                        m_hold[i]++;
                        if (m_hold[i] == LC - 1) m_long[i] = 1'b1;
                    end
                end else begin
                    m_hold[i] = 0;
                end
            end
`endif
        end
    end

    // Compare DUT against the model mid-cycle and log every accepted command.
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("model_valid", cmd_valid, m_valid);
            if (m_valid) begin
                chk("model_idx", cmd_idx, m_idx);
                chk("model_long", cmd_long, m_cmdlong);
            end
            chk("model_drop", drop_cnt, m_drops);
            if (cmd_valid && cmd_ready) hs_q.push_back({cmd_long, cmd_idx});
        end
    end

    initial begin : stim
        int seq [3];
        seq = '{0, 1, 3};

        rst = 1'b1; btn_down = 4'b1111;
        tick(); tick();
        btn_down = '0;
        chk("rst_valid", cmd_valid, 0);
        chk("rst_idx", cmd_idx, 0);
        chk("rst_long", cmd_long, 0);
        chk("rst_drop", drop_cnt, 0);
        rst = 1'b0;
        tick(); tick();
        chk("rst_press_ignored", cmd_valid, 0);

        cmd_ready = 1'b1; btn_down = 4'b0100;
        tick(); btn_down = '0;
        chk("single_lat1", cmd_valid, 0);
        tick();
        chk("single_valid", cmd_valid, 1);
        chk("single_idx", cmd_idx, 2);
        chk("single_long", cmd_long, 0);
        tick();
        chk("single_once", cmd_valid, 0);

        rst = 1'b1; tick(); rst = 1'b0;
        btn_down = 4'b1011;
        tick(); btn_down = '0;
        chk("multi_lat1", cmd_valid, 0);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("multi_valid", cmd_valid, 1);
            chk("multi_idx", cmd_idx, seq[s]);
        end
        tick();
        chk("multi_end", cmd_valid, 0);

        cmd_ready = 1'b0; btn_down = 4'b0010;
        tick(); btn_down = '0;
        tick();
        chk("stall_first", cmd_valid, 1);
        chk("stall_first_idx", cmd_idx, 1);
        for (int c = 0; c < 20; c++) begin
            if (c == 3 || c == 11) btn_down = 4'b0010;
            tick(); btn_down = '0;
            chk("stall_valid", cmd_valid, 1);
            chk("stall_idx", cmd_idx, 1);
        end
        chk("stall_drop", drop_cnt, 1);
        cmd_ready = 1'b1;
        tick();
        chk("stall_reoffer", cmd_valid, 1);
        chk("stall_reoffer_idx", cmd_idx, 1);
        tick();
        chk("stall_end", cmd_valid, 0);

        btn_down = 4'b0001;
        tick(); tick(); btn_down = '0;
        chk("repress_first", cmd_valid, 1);
        chk("repress_first_idx", cmd_idx, 0);
        tick();
        chk("repress_second", cmd_valid, 1);
        chk("repress_second_idx", cmd_idx, 0);
        tick();
        chk("repress_end", cmd_valid, 0);
        chk("repress_drop", drop_cnt, 1);

        cmd_ready = 1'b0; btn_down = 4'b1000;
        tick(); btn_down = '0;
        tick();
        chk("rstmid_offer", cmd_valid, 1);
        chk("rstmid_idx", cmd_idx, 3);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rstmid_valid", cmd_valid, 0);
        chk("rstmid_drop", drop_cnt, 0);
        cmd_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rstmid_no_reoffer", cmd_valid, 0);
        end

        cmd_ready = 1'b0; btn_down = 4'b0011;
        tick(); btn_down = '0;
        tick();
        chk("ovr_idx0", cmd_idx, 0);
        btn_down = 4'b0011; tick(); btn_down = '0;
        chk("ovr_drop1", drop_cnt, 1);
        btn_down = 4'b0011; tick(); btn_down = '0;
        chk("ovr_drop2_per_edge", drop_cnt, 2);
        cmd_ready = 1'b1;
        tick(); chk("ovr_next1", cmd_idx, 1);
        tick(); chk("ovr_next0", cmd_idx, 0);
        tick(); chk("ovr_end", cmd_valid, 0);

        cmd_ready = 1'b0; btn_down = 4'b0100;
        for (int c = 0; c < 300; c++) tick();
        btn_down = '0;
        chk("sat_drop", drop_cnt, 255);
        cmd_ready = 1'b1;
        tick(); chk("sat_reoffer_idx", cmd_idx, 2);
        tick(); chk("sat_end", cmd_valid, 0);
        chk("sat_hold", drop_cnt, 255);

        rst = 1'b1; tick(); rst = 1'b0;
        cmd_ready = 1'b1;
        hs_q.delete();
        btn_down = 4'b0010; btn_state = 4'b0010;
        tick(); btn_down = '0;
        for (int c = 0; c < 39; c++) tick();
        btn_state = '0;
        for (int c = 0; c < 5; c++) tick();
`ifdef BUTTON_LONG_PRESS_EN
        chk("long_count", hs_q.size(), 2);
        if (hs_q.size() >= 2) begin
            chk("long_first_short", hs_q[0], 3'b001);
            chk("long_second_long", hs_q[1], 3'b101);
        end
`else
        chk("long_count", hs_q.size(), 1);
        if (hs_q.size() >= 1) chk("long_first_short", hs_q[0], 3'b001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
